// File: rtl/ram_write_ctrl.sv
// Push-button driven write controller for a 32x4 RAM.
// A debounced press captures the switch nibble and an address (manual or auto-incrementing
// pointer), issues one write-enable pulse, then waits for the button to be released.
module ram_write_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [3:0] sw_data,
    input  logic [4:0] sw_addr,
    input  logic       auto_mode,
    output logic [3:0] wr_data,
    output logic [4:0] wr_addr,
    output logic       wren,
    output logic       busy,
    output logic [5:0] wr_count,
    output logic       full
);

    localparam logic [CNT_W-1:0] CntMax   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]       CountMax = 6'd32;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StWrite,
        StHold
    } state_e;

    state_e           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             btn_stable_q;
    logic             btn_stable_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       auto_ptr_q;
    // auto_mode as seen at capture; governs the pointer update of this write only
    logic             auto_q;
    logic             press;

    // Two-flop synchronizer; resets to the released level
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: accept a new level only after it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            btn_stable_q      <= 1'b1;
            btn_stable_prev_q <= 1'b1;
            cnt_q             <= '0;
        end else begin
            btn_stable_prev_q <= btn_stable_q;
            if (sync2_q == btn_stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                btn_stable_q <= sync2_q;
                cnt_q        <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Press = debounced level falling 1 -> 0
    assign press = btn_stable_prev_q & ~btn_stable_q;

    // Write FSM with registered outputs, pointer and write counter
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wren       <= 1'b0;
            busy       <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            auto_ptr_q <= '0;
            auto_q     <= 1'b0;
            wr_count   <= '0;
            full       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (press) begin
                        state_q <= StCapture;
                        busy    <= 1'b1;
                        wr_data <= sw_data;
                        wr_addr <= auto_mode ? auto_ptr_q : sw_addr;
                        auto_q  <= auto_mode;
                    end
                end
                StCapture: begin
                    state_q <= StWrite;
                    wren    <= 1'b1;
                end
                StWrite: begin
                    state_q <= StHold;
                    wren    <= 1'b0;
                    if (auto_q) begin
                        auto_ptr_q <= auto_ptr_q + 5'd1;
                    end
                    if (wr_count != CountMax) begin
                        wr_count <= wr_count + 6'd1;
                        full     <= (wr_count == CountMax - 6'd1);
                    end
                end
                StHold: begin
                    // Only a debounced release rearms the FSM
                    if (btn_stable_q) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    wren    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Scoreboard bench for ram_write_ctrl with a short debounce window.
module tb_ram_write_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_n    = 1'b1;
    logic [3:0] sw_data  = '0;
    logic [4:0] sw_addr  = '0;
    logic       auto_mode = 1'b0;
    logic [3:0] wr_data;
    logic [4:0] wr_addr;
    logic       wren;
    logic       busy;
    logic [5:0] wr_count;
    logic       full;

    ram_write_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .btn_n    (btn_n),
        .sw_data  (sw_data),
        .sw_addr  (sw_addr),
        .auto_mode(auto_mode),
        .wr_data  (wr_data),
        .wr_addr  (wr_addr),
        .wren     (wren),
        .busy     (busy),
        .wr_count (wr_count),
        .full     (full)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] data;
        logic [5:0] cnt;
        logic       full;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [4:0] m_ptr  = '0;
    logic [5:0] m_cnt  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Reference model: expected write for the next press, then advance model state
    task automatic push_write(input logic [3:0] d, input logic am, input logic [4:0] sa);
        exp_t e;
        e.addr = am ? m_ptr : sa;
        e.data = d;
        e.cnt  = m_cnt;
        e.full = (m_cnt == 6'd32);
        sb_q.push_back(e);
        if (am) m_ptr = m_ptr + 5'd1;
        if (m_cnt != 6'd32) m_cnt = m_cnt + 6'd1;
    endtask

    task automatic press(input logic [3:0] d, input logic am, input logic [4:0] sa);
        sw_data   = d;
        auto_mode = am;
        sw_addr   = sa;
        push_write(d, am, sa);
        btn_n = 1'b0;
        tick(12);
        btn_n = 1'b1;
        tick(12);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_ptr = '0;
        m_cnt = '0;
        tick(1);
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (!rst && wren) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wren: got write addr=%0h data=%0h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("wr_count_at_write", 32'(wr_count), 32'(e.cnt));
                check("full_at_write", 32'(full), 32'(e.full));
                check("busy_at_write", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        logic seen;
        logic early;

        // Reset state
        tick(2);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        tick(2);

        // Clean press in auto mode
        press(4'hA, 1'b1, 5'h00);
        check("count_after_first", 32'(wr_count), 32'd1);

        // Bouncing button: no write until the level holds
        sw_data   = 4'h3;
        auto_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0;
            tick(2);
            btn_n = 1'b1;
            tick(2);
        end
        push_write(4'h3, 1'b1, 5'h00);
        btn_n = 1'b0;
        tick(12);
        btn_n = 1'b1;
        tick(12);

        // Long hold: one write, busy until release is debounced
        sw_data = 4'h7;
        push_write(4'h7, 1'b1, 5'h00);
        btn_n = 1'b0;
        tick(100);
        check("busy_during_hold", 32'(busy), 32'd1);
        btn_n = 1'b1;
        tick(12);
        check("busy_after_release", 32'(busy), 32'd0);

        // Manual address; switch change during HOLD must not alter the write
        sw_data   = 4'h5;
        sw_addr   = 5'h13;
        auto_mode = 1'b0;
        push_write(4'h5, 1'b0, 5'h13);
        btn_n = 1'b0;
        tick(12);
        sw_data = 4'h9;
        tick(3);
        check("wr_data_held", 32'(wr_data), 32'h5);
        btn_n = 1'b1;
        tick(12);

        // Auto pointer untouched by the manual write
        press(4'hC, 1'b1, 5'h00);

        // 34 presses from reset: wrap and saturation
        do_reset();
        for (int i = 0; i < 34; i++) begin
            press(4'(i), 1'b1, 5'h00);
            if (i == 30) check("full_before_32", 32'(full), 32'd0);
        end
        check("count_saturated", 32'(wr_count), 32'd32);
        check("full_set", 32'(full), 32'd1);

        // Reset in the WRITE cycle, button kept low across reset
        sw_data = 4'h6;
        push_write(4'h6, 1'b1, 5'h00);
        btn_n = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLOCK_50);
            if (wren) seen = 1'b1;
        end
        check("wren_seen_before_rst", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_in_write_wren", 32'(wren), 32'd0);
        check("rst_in_write_busy", 32'(busy), 32'd0);
        check("rst_in_write_count", 32'(wr_count), 32'd0);
        check("rst_in_write_addr", 32'(wr_addr), 32'd0);
        check("rst_in_write_data", 32'(wr_data), 32'd0);
        check("rst_in_write_full", 32'(full), 32'd0);
        tick(2);
        rst   = 1'b0;
        m_ptr = '0;
        m_cnt = '0;
        sw_data = 4'hE;
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            if (wren) early = 1'b1;
        end
        check("no_early_write_after_rst", 32'(early), 32'd0);
        push_write(4'hE, 1'b1, 5'h00);
        tick(12);
        btn_n = 1'b1;
        tick(12);
        check("count_after_rst_write", 32'(wr_count), 32'd1);

        tick(5);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
